// File: rtl/mc_ctrl.sv
// Multi-cycle MIPS control FSM with retired-instruction counter.
// Define MC_CTRL_JAL_JR_EN to decode jal/jr; otherwise they take the illegal path.
module mc_ctrl #(
  parameter int unsigned ALUOP_W = 5,
  parameter int unsigned CNT_W   = 32
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic [5:0]         opcode,
  input  logic [5:0]         func,
  input  logic               zero,
  input  logic               mem_ready,
  output logic               pc_we,
  output logic [1:0]         pc_sel,
  output logic               ir_we,
  output logic               iord,
  output logic               mem_read,
  output logic               mem_write,
  output logic               reg_write,
  output logic [1:0]         reg_dst,
  output logic [1:0]         data_to_reg,
  output logic [1:0]         alu_src_a,
  output logic [1:0]         alu_src_b,
  output logic               ext_op,
  output logic [ALUOP_W-1:0] alu_ctrl,
  output logic [2:0]         state,
  output logic               illegal,
  output logic [CNT_W-1:0]   retired
);

  localparam logic [5:0] OP_R    = 6'b000000;
  localparam logic [5:0] OP_ORI  = 6'b001101;
  localparam logic [5:0] OP_LUI  = 6'b001111;
  localparam logic [5:0] OP_SLTI = 6'b001010;
  localparam logic [5:0] OP_LW   = 6'b100011;
  localparam logic [5:0] OP_SW   = 6'b101011;
  localparam logic [5:0] OP_BEQ  = 6'b000100;
  localparam logic [5:0] OP_BNE  = 6'b000101;
  localparam logic [5:0] OP_J    = 6'b000010;
  localparam logic [5:0] F_ADD   = 6'b100000;
  localparam logic [5:0] F_ADDU  = 6'b100001;
  localparam logic [5:0] F_SUB   = 6'b100010;
  localparam logic [5:0] F_SUBU  = 6'b100011;
  localparam logic [5:0] F_SLT   = 6'b101010;
  localparam logic [5:0] F_SLL   = 6'b000000;
`ifdef MC_CTRL_JAL_JR_EN
  localparam logic [5:0] OP_JAL  = 6'b000011;
  localparam logic [5:0] F_JR    = 6'b001000;
`endif

  // ALU operation codes, zero-extended to ALUOP_W
  localparam logic [4:0] ALU_NOP = 5'd0;
  localparam logic [4:0] ALU_ADD = 5'd1;
  localparam logic [4:0] ALU_SUB = 5'd2;
  localparam logic [4:0] ALU_OR  = 5'd4;
  localparam logic [4:0] ALU_SLT = 5'd5;
  localparam logic [4:0] ALU_SLL = 5'd7;
  localparam logic [4:0] ALU_LUI = 5'd8;

  typedef enum logic [2:0] {
    S_IF  = 3'd0,
    S_ID  = 3'd1,
    S_EX  = 3'd2,
    S_MEM = 3'd3,
    S_WB  = 3'd4,
    S_ILL = 3'd5
  } state_t;

  typedef enum logic [3:0] {
    C_BAD, C_RALU, C_SLL, C_ORI, C_LUI, C_SLTI, C_LW, C_SW,
    C_BEQ, C_BNE, C_J, C_JAL, C_JR
  } cls_t;

  state_t     state_q, state_d;
  cls_t       cls;
  logic [4:0] r_op;
  logic       retire;

  // Instruction classification from the IR fields
  always_comb begin
    cls  = C_BAD;
    r_op = ALU_NOP;
    case (opcode)
      OP_R: begin
        case (func)
          F_ADD, F_ADDU: begin cls = C_RALU; r_op = ALU_ADD; end
          F_SUB, F_SUBU: begin cls = C_RALU; r_op = ALU_SUB; end
          F_SLT:         begin cls = C_RALU; r_op = ALU_SLT; end
          F_SLL:         cls = C_SLL;
`ifdef MC_CTRL_JAL_JR_EN
          F_JR:          cls = C_JR;
`endif
          default:       cls = C_BAD;
        endcase
      end
      OP_ORI:  cls = C_ORI;
      OP_LUI:  cls = C_LUI;
      OP_SLTI: cls = C_SLTI;
      OP_LW:   cls = C_LW;
      OP_SW:   cls = C_SW;
      OP_BEQ:  cls = C_BEQ;
      OP_BNE:  cls = C_BNE;
      OP_J:    cls = C_J;
`ifdef MC_CTRL_JAL_JR_EN
      OP_JAL:  cls = C_JAL;
`endif
      default: cls = C_BAD;
    endcase
  end

  // Next state and control outputs; reset gates every output to zero
  always_comb begin
    state_d     = state_q;
    retire      = 1'b0;
    pc_we       = 1'b0;
    pc_sel      = 2'b00;
    ir_we       = 1'b0;
    iord        = 1'b0;
    mem_read    = 1'b0;
    mem_write   = 1'b0;
    reg_write   = 1'b0;
    reg_dst     = 2'b00;
    data_to_reg = 2'b00;
    alu_src_a   = 2'b00;
    alu_src_b   = 2'b00;
    ext_op      = 1'b0;
    alu_ctrl    = ALUOP_W'(ALU_NOP);
    illegal     = 1'b0;
    if (rst_n) begin
      case (state_q)
        S_IF: begin
          mem_read = 1'b1;
          if (mem_ready) begin
            ir_we   = 1'b1;
            pc_we   = 1'b1;
            state_d = S_ID;
          end
        end
        S_ID: begin
          alu_src_b = 2'b10;
          ext_op    = 1'b1;
          alu_ctrl  = ALUOP_W'(ALU_ADD);
          state_d   = (cls == C_BAD) ? S_ILL : S_EX;
        end
        S_EX: begin
          state_d = S_WB;
          case (cls)
            C_RALU: begin alu_src_a = 2'b01; alu_ctrl = ALUOP_W'(r_op); end
            C_SLL: begin
              alu_src_a = 2'b10;
              alu_src_b = 2'b11;
              alu_ctrl  = ALUOP_W'(ALU_SLL);
            end
            C_ORI: begin
              alu_src_a = 2'b01;
              alu_src_b = 2'b01;
              alu_ctrl  = ALUOP_W'(ALU_OR);
            end
            C_LUI: begin
              alu_src_a = 2'b01;
              alu_src_b = 2'b01;
              alu_ctrl  = ALUOP_W'(ALU_LUI);
            end
            C_SLTI: begin
              alu_src_a = 2'b01;
              alu_src_b = 2'b01;
              ext_op    = 1'b1;
              alu_ctrl  = ALUOP_W'(ALU_SLT);
            end
            C_LW, C_SW: begin
              alu_src_a = 2'b01;
              alu_src_b = 2'b01;
              ext_op    = 1'b1;
              alu_ctrl  = ALUOP_W'(ALU_ADD);
              state_d   = S_MEM;
            end
            C_BEQ, C_BNE: begin
              alu_src_a = 2'b01;
              alu_ctrl  = ALUOP_W'(ALU_SUB);
              if ((cls == C_BEQ && zero) || (cls == C_BNE && !zero)) begin
                pc_we  = 1'b1;
                pc_sel = 2'b01;
              end
              retire  = 1'b1;
              state_d = S_IF;
            end
            C_J: begin
              pc_we   = 1'b1;
              pc_sel  = 2'b10;
              retire  = 1'b1;
              state_d = S_IF;
            end
            C_JAL: begin
              pc_we       = 1'b1;
              pc_sel      = 2'b10;
              reg_write   = 1'b1;
              reg_dst     = 2'b10;
              data_to_reg = 2'b10;
              retire      = 1'b1;
              state_d     = S_IF;
            end
            C_JR: begin
              pc_we   = 1'b1;
              pc_sel  = 2'b11;
              retire  = 1'b1;
              state_d = S_IF;
            end
            default: state_d = S_ILL;
          endcase
        end
        S_MEM: begin
          iord = 1'b1;
          if (cls == C_SW) mem_write = 1'b1;
          else             mem_read  = 1'b1;
          if (mem_ready) begin
            if (cls == C_SW) begin
              retire  = 1'b1;
              state_d = S_IF;
            end else begin
              state_d = S_WB;
            end
          end
        end
        S_WB: begin
          reg_write = 1'b1;
          if (cls == C_RALU || cls == C_SLL) reg_dst = 2'b01;
          if (cls == C_LW) data_to_reg = 2'b01;
          retire  = 1'b1;
          state_d = S_IF;
        end
        S_ILL: begin
          illegal = 1'b1;
          state_d = S_IF;
        end
        default: state_d = S_IF;
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= S_IF;
      retired <= '0;
    end else begin
      state_q <= state_d;
      if (retire) retired <= retired + CNT_W'(1);
    end
  end

  assign state = state_q;

endmodule

// File: tb/tb_mc_ctrl.sv
// Self-checking bench for mc_ctrl: directed cases plus a random instruction stream
// checked cycle by cycle against a per-instruction phase-sequence model.
module tb_mc_ctrl;
  localparam int unsigned ALUOP_W = 5;
  localparam int unsigned CNT_W   = 4;

  localparam logic [4:0] A_ADD = 5'd1;
  localparam logic [4:0] A_SUB = 5'd2;
  localparam logic [4:0] A_OR  = 5'd4;
  localparam logic [4:0] A_SLT = 5'd5;
  localparam logic [4:0] A_SLL = 5'd7;
  localparam logic [4:0] A_LUI = 5'd8;

  logic clk = 1'b0;
  logic rst_n;
  logic [5:0] opcode, func;
  logic zero, mem_ready;
  logic pc_we, ir_we, iord, mem_read, mem_write, reg_write, ext_op, illegal;
  logic [1:0] pc_sel, reg_dst, data_to_reg, alu_src_a, alu_src_b;
  logic [ALUOP_W-1:0] alu_ctrl;
  logic [2:0] state;
  logic [CNT_W-1:0] retired;

  int checks = 0;
  int errors = 0;
  logic [CNT_W-1:0] cnt = '0;

  mc_ctrl #(.ALUOP_W(ALUOP_W), .CNT_W(CNT_W)) dut (
    .clk(clk), .rst_n(rst_n), .opcode(opcode), .func(func), .zero(zero),
    .mem_ready(mem_ready), .pc_we(pc_we), .pc_sel(pc_sel), .ir_we(ir_we),
    .iord(iord), .mem_read(mem_read), .mem_write(mem_write),
    .reg_write(reg_write), .reg_dst(reg_dst), .data_to_reg(data_to_reg),
    .alu_src_a(alu_src_a), .alu_src_b(alu_src_b), .ext_op(ext_op),
    .alu_ctrl(alu_ctrl), .state(state), .illegal(illegal), .retired(retired)
  );

  always #5 clk = ~clk;

  typedef enum int {K_ALU, K_LW, K_SW, K_BR, K_J, K_JAL, K_JR, K_ILL} kind_t;

  typedef struct {
    logic [5:0] op;
    logic [5:0] fn;
    kind_t      kind;
    logic [1:0] dst;
    logic [1:0] dtr;
    logic [1:0] a;
    logic [1:0] b;
    logic       ext;
    logic [4:0] alu;
    logic       bne;
  } ins_t;

  typedef struct packed {
    logic [2:0]       st;
    logic             pc_we;
    logic [1:0]       pc_sel;
    logic             ir_we;
    logic             iord;
    logic             mem_read;
    logic             mem_write;
    logic             reg_write;
    logic [1:0]       dst;
    logic [1:0]       dtr;
    logic [1:0]       a;
    logic [1:0]       b;
    logic             ext;
    logic [4:0]       alu;
    logic             ill;
    logic [CNT_W-1:0] ret;
  } obs_t;

  localparam int N_INS = 18;

  // Instruction table: encoding, class and the EX/WB controls it needs
  function automatic ins_t lookup(input int idx);
    ins_t r;
    r = '{6'b111111, 6'b000000, K_ILL, 2'b00, 2'b00, 2'b00, 2'b00, 1'b0, 5'd0, 1'b0};
    case (idx)
      0:  r = '{6'b000000, 6'b100000, K_ALU, 2'b01, 2'b00, 2'b01, 2'b00, 1'b0, A_ADD, 1'b0};
      1:  r = '{6'b000000, 6'b100001, K_ALU, 2'b01, 2'b00, 2'b01, 2'b00, 1'b0, A_ADD, 1'b0};
      2:  r = '{6'b000000, 6'b100010, K_ALU, 2'b01, 2'b00, 2'b01, 2'b00, 1'b0, A_SUB, 1'b0};
      3:  r = '{6'b000000, 6'b100011, K_ALU, 2'b01, 2'b00, 2'b01, 2'b00, 1'b0, A_SUB, 1'b0};
      4:  r = '{6'b000000, 6'b101010, K_ALU, 2'b01, 2'b00, 2'b01, 2'b00, 1'b0, A_SLT, 1'b0};
      5:  r = '{6'b000000, 6'b000000, K_ALU, 2'b01, 2'b00, 2'b10, 2'b11, 1'b0, A_SLL, 1'b0};
      6:  r = '{6'b001101, 6'b000000, K_ALU, 2'b00, 2'b00, 2'b01, 2'b01, 1'b0, A_OR,  1'b0};
      7:  r = '{6'b001111, 6'b000000, K_ALU, 2'b00, 2'b00, 2'b01, 2'b01, 1'b0, A_LUI, 1'b0};
      8:  r = '{6'b001010, 6'b000000, K_ALU, 2'b00, 2'b00, 2'b01, 2'b01, 1'b1, A_SLT, 1'b0};
      9:  r = '{6'b100011, 6'b000000, K_LW,  2'b00, 2'b01, 2'b01, 2'b01, 1'b1, A_ADD, 1'b0};
      10: r = '{6'b101011, 6'b000000, K_SW,  2'b00, 2'b00, 2'b01, 2'b01, 1'b1, A_ADD, 1'b0};
      11: r = '{6'b000100, 6'b000000, K_BR,  2'b00, 2'b00, 2'b01, 2'b00, 1'b0, A_SUB, 1'b0};
      12: r = '{6'b000101, 6'b000000, K_BR,  2'b00, 2'b00, 2'b01, 2'b00, 1'b0, A_SUB, 1'b1};
      13: r = '{6'b000010, 6'b000000, K_J,   2'b00, 2'b00, 2'b00, 2'b00, 1'b0, 5'd0,  1'b0};
`ifdef MC_CTRL_JAL_JR_EN
      14: r = '{6'b000011, 6'b000000, K_JAL, 2'b00, 2'b00, 2'b00, 2'b00, 1'b0, 5'd0,  1'b0};
      15: r = '{6'b000000, 6'b001000, K_JR,  2'b00, 2'b00, 2'b00, 2'b00, 1'b0, 5'd0,  1'b0};
`else
      14: r = '{6'b000011, 6'b000000, K_ILL, 2'b00, 2'b00, 2'b00, 2'b00, 1'b0, 5'd0,  1'b0};
      15: r = '{6'b000000, 6'b001000, K_ILL, 2'b00, 2'b00, 2'b00, 2'b00, 1'b0, 5'd0,  1'b0};
`endif
      17: r = '{6'b000000, 6'b100100, K_ILL, 2'b00, 2'b00, 2'b00, 2'b00, 1'b0, 5'd0,  1'b0};
      default: ;
    endcase
    return r;
  endfunction

  // Expected outputs for one cycle given the phase the instruction is in
  function automatic obs_t exp_of(input int ph, input ins_t i, input logic rdy,
                                  input logic z, input logic [CNT_W-1:0] c);
    obs_t e;
    e = '0;
    e.st  = 3'(ph);
    e.ret = c;
    case (ph)
      0: begin
        e.mem_read = 1'b1;
        if (rdy) begin e.ir_we = 1'b1; e.pc_we = 1'b1; end
      end
      1: begin e.b = 2'b10; e.ext = 1'b1; e.alu = A_ADD; end
      2: begin
        if (i.kind inside {K_ALU, K_LW, K_SW, K_BR}) begin
          e.a = i.a; e.b = i.b; e.ext = i.ext; e.alu = i.alu;
        end
        if (i.kind == K_BR && (i.bne ? !z : z)) begin
          e.pc_we = 1'b1; e.pc_sel = 2'b01;
        end
        if (i.kind == K_J)  begin e.pc_we = 1'b1; e.pc_sel = 2'b10; end
        if (i.kind == K_JR) begin e.pc_we = 1'b1; e.pc_sel = 2'b11; end
        if (i.kind == K_JAL) begin
          e.pc_we = 1'b1; e.pc_sel = 2'b10; e.reg_write = 1'b1;
          e.dst = 2'b10; e.dtr = 2'b10;
        end
      end
      3: begin
        e.iord = 1'b1;
        if (i.kind == K_SW) e.mem_write = 1'b1;
        else                e.mem_read  = 1'b1;
      end
      4: begin e.reg_write = 1'b1; e.dst = i.dst; e.dtr = i.dtr; end
      default: e.ill = 1'b1;
    endcase
    return e;
  endfunction

  function automatic obs_t observed();
    return {state, pc_we, pc_sel, ir_we, iord, mem_read, mem_write, reg_write,
            reg_dst, data_to_reg, alu_src_a, alu_src_b, ext_op, alu_ctrl[4:0],
            illegal, retired};
  endfunction

  task automatic check(input obs_t e, input string tag);
    obs_t o;
    o = observed();
    checks++;
    assert (o === e) else begin
      errors++;
      $error("FAIL %s observed=%h expected=%h", tag, o, e);
    end
  endtask

  // One cycle: drive mem_ready, check just after the falling edge, move to next one
  task automatic step(input int ph, input logic rdy, input ins_t i, input logic z, input string tag);
    mem_ready = (ph == 0 || ph == 3) ? rdy : 1'($urandom_range(0, 1));
    #1;
    check(exp_of(ph, i, rdy, z, cnt), tag);
    @(negedge clk);
  endtask

  task automatic run_instr(input int idx, input logic z, input int if_wait,
                           input int mem_wait, input string tag);
    ins_t i;
    int   ph_q[$];
    bit   rdy_q[$];
    i = lookup(idx);
    opcode = i.op;
    func   = (i.op == 6'b000000) ? i.fn : 6'($urandom);
    zero   = z;
    for (int k = 0; k < if_wait; k++) begin ph_q.push_back(0); rdy_q.push_back(0); end
    ph_q.push_back(0); rdy_q.push_back(1);
    ph_q.push_back(1); rdy_q.push_back(1);
    if (i.kind == K_ILL) begin
      ph_q.push_back(5); rdy_q.push_back(1);
    end else begin
      ph_q.push_back(2); rdy_q.push_back(1);
      if (i.kind == K_LW || i.kind == K_SW) begin
        for (int k = 0; k < mem_wait; k++) begin ph_q.push_back(3); rdy_q.push_back(0); end
        ph_q.push_back(3); rdy_q.push_back(1);
      end
      if (i.kind == K_ALU || i.kind == K_LW) begin ph_q.push_back(4); rdy_q.push_back(1); end
    end
    foreach (ph_q[k]) step(ph_q[k], rdy_q[k], i, z, tag);
    if (i.kind != K_ILL) cnt = cnt + CNT_W'(1);
  endtask

  initial begin
    obs_t zero_obs;
    ins_t lw_i;
    zero_obs = '0;
    rst_n = 1'b0; opcode = 6'd0; func = 6'd0; zero = 1'b0; mem_ready = 1'b1;
    #12;
    check(zero_obs, "reset_state");
    @(negedge clk);
    rst_n = 1'b1;

    run_instr(1, 1'b0, 0, 0, "addu");
    run_instr(9, 1'b0, 0, 3, "lw_wait3");
    run_instr(11, 1'b1, 0, 0, "beq_taken");
    run_instr(11, 1'b0, 0, 0, "beq_not_taken");
    run_instr(12, 1'b0, 0, 0, "bne_taken");
    run_instr(12, 1'b1, 0, 0, "bne_not_taken");
    run_instr(16, 1'b0, 0, 0, "illegal_op");
    run_instr(17, 1'b0, 0, 0, "illegal_func");
    run_instr(14, 1'b0, 0, 0, "jal");
    run_instr(15, 1'b0, 0, 0, "jr");
    run_instr(13, 1'b0, 2, 0, "j_ifwait");
    run_instr(10, 1'b0, 1, 2, "sw_wait");
    run_instr(5, 1'b0, 0, 0, "sll");

    // Reset in the middle of a stalled lw memory access
    lw_i = lookup(9);
    opcode = lw_i.op; func = 6'd0;
    step(0, 1'b1, lw_i, 1'b0, "abort_if");
    step(1, 1'b1, lw_i, 1'b0, "abort_id");
    step(2, 1'b1, lw_i, 1'b0, "abort_ex");
    step(3, 1'b0, lw_i, 1'b0, "abort_mem");
    mem_ready = 1'b0;
    #1;
    rst_n = 1'b0;
    #1;
    check(zero_obs, "rst_mid_mem");
    cnt = '0;
    @(negedge clk);
    #1;
    check(zero_obs, "rst_held");
    rst_n = 1'b1;
    @(negedge clk);
    run_instr(9, 1'b0, 0, 0, "lw_refetch");

    for (int n = 0; n < 60; n++)
      run_instr(int'($urandom_range(0, N_INS - 1)), 1'($urandom_range(0, 1)),
                int'($urandom_range(0, 2)), int'($urandom_range(0, 2)), "random");

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
